// File: rtl/stream_lane_sum_pkg.sv
// Shared types and width helpers for the streaming lane-sum front end.
package lane_sum_pkg;

    typedef enum logic [1:0] {
        FILL,
        SUM,
        OUT
    } state_t;

    function automatic int lane_sum_width(input int bw, input int n);
        return bw + $clog2(n);
    endfunction

endpackage

// File: rtl/stream_lane_sum_adder.sv
// Signed adder tree: sign-extends every lane, pads to a power-of-two leaf count
// with zeros and reduces pairwise in a heap-ordered node array.
module adder
    import lane_sum_pkg::*;
#(
    parameter int bit_width  = 8,
    parameter int num_inputs = 4
) (
    input  logic [num_inputs-1:0][bit_width-1:0]                                   in,
    output logic [lane_sum_width(bit_width, num_inputs)-1:0]                       sum,
    output logic [2*(1 << $clog2(num_inputs))-1:1][lane_sum_width(bit_width, num_inputs)-1:0] level_sum
);

    localparam int W = lane_sum_width(bit_width, num_inputs);
    localparam int P = 1 << $clog2(num_inputs);

    // node[1] is the root; node[P..2P-1] are the leaves
    logic [2*P-1:1][W-1:0] node;

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < num_inputs) begin : g_real
            assign node[P+i] = W'($signed(in[i]));
        end else begin : g_pad
            assign node[P+i] = '0;
        end
    end

    for (genvar i = 1; i < P; i++) begin : g_node
        assign node[i] = node[2*i] + node[2*i+1];
    end

    assign sum       = node[1];
    assign level_sum = node;

endmodule

// File: rtl/stream_lane_sum.sv
// Stream front end: packs signed samples into lanes, sums them with the adder
// tree and presents the registered sum on a valid/ready output stream.
module stream_lane_sum
    import lane_sum_pkg::*;
#(
    parameter int bit_width     = 8,
    parameter int num_inputs    = 4,
    parameter int add_out_width = lane_sum_width(bit_width, num_inputs)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [bit_width-1:0]                 s_data,
    input  logic                                 s_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [add_out_width-1:0]             m_sum,
    output logic [$clog2(num_inputs+1)-1:0]      m_count
);

    localparam int CW = $clog2(num_inputs + 1);

    state_t                              state_q, state_d;
    logic [num_inputs-1:0][bit_width-1:0] lanes_q, lanes_d;
    logic [CW-1:0]                       idx_q, idx_d;
    logic [add_out_width-1:0]            m_sum_q, m_sum_d;
    logic [CW-1:0]                       m_count_q, m_count_d;
    logic                                m_valid_q, m_valid_d;
    logic                                s_ready_q, s_ready_d;
    logic [add_out_width-1:0]            tree_sum;

    adder #(
        .bit_width (bit_width),
        .num_inputs(num_inputs)
    ) u_tree (
        .in       (lanes_q),
        .sum      (tree_sum),
        .level_sum()
    );

    always_comb begin
        state_d   = state_q;
        lanes_d   = lanes_q;
        idx_d     = idx_q;
        m_sum_d   = m_sum_q;
        m_count_d = m_count_q;
        m_valid_d = m_valid_q;
        s_ready_d = s_ready_q;
        case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    for (int unsigned i = 0; i < num_inputs; i++) begin
                        if (idx_q == CW'(i)) lanes_d[i] = s_data;
                    end
                    idx_d = idx_q + CW'(1);
                    // a full vector and s_last on the same beat close one vector
                    if (idx_q == CW'(num_inputs - 1) || s_last) begin
                        state_d   = SUM;
                        s_ready_d = 1'b0;
                    end
                end
            end
            SUM: begin
                m_sum_d   = tree_sum;
                m_count_d = idx_q;
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    lanes_d   = '0;
                    idx_d     = '0;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d   = FILL;
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            lanes_q   <= '0;
            idx_q     <= '0;
            m_sum_q   <= '0;
            m_count_q <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            lanes_q   <= lanes_d;
            idx_q     <= idx_d;
            m_sum_q   <= m_sum_d;
            m_count_q <= m_count_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_sum   = m_sum_q;
    assign m_count = m_count_q;

endmodule

// File: tb/tb_stream_lane_sum.sv
// Bench for stream_lane_sum: directed scenarios with literal expectations plus
// randomized vectors checked every cycle against a behavioural stream model.
module tb_stream_lane_sum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_ready, s_last, m_valid, m_ready;
    logic [7:0] s_data;
    logic [9:0] m_sum;
    logic [2:0] m_count;

    logic        s_valid5, s_ready5, s_last5, m_valid5, m_ready5;
    logic [7:0]  s_data5;
    logic [10:0] m_sum5;
    logic [2:0]  m_count5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    always #5 clk = ~clk;

    stream_lane_sum #(
        .bit_width (8),
        .num_inputs(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_sum  (m_sum),
        .m_count(m_count)
    );

    stream_lane_sum #(
        .bit_width (8),
        .num_inputs(5)
    ) dut5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid5),
        .s_ready(s_ready5),
        .s_data (s_data5),
        .s_last (s_last5),
        .m_valid(m_valid5),
        .m_ready(m_ready5),
        .m_sum  (m_sum5),
        .m_count(m_count5)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end

    // Stream model: a vector closes after 4 samples or on s_last; its result is
    // visible two cycles later and input stays blocked until it is taken.
    int acc = 0, cnt = 0, valid_from = 0, exp_sum = 0, exp_cnt = 0;
    bit busy = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            acc = 0; cnt = 0; busy = 0;
        end else begin
            check("s_ready", int'(s_ready), int'(!busy));
            check("m_valid", int'(m_valid), int'(busy && cyc >= valid_from));
            if (busy && cyc >= valid_from) begin
                check("m_sum", $signed(m_sum), exp_sum);
                check("m_count", int'(m_count), exp_cnt);
                if (m_ready) busy = 0;
            end
            if (s_valid && s_ready) begin
                acc = acc + $signed(s_data);
                cnt++;
                if (cnt == 4 || s_last) begin
                    busy = 1; valid_from = cyc + 2;
                    exp_sum = acc; exp_cnt = cnt;
                    acc = 0; cnt = 0;
                end
            end
        end
    end

    task automatic send(input int d, input bit l);
        int n = 0;
        bit took = 0;
        s_valid = 1'b1; s_data = 8'(d); s_last = l;
        while (!took && n < 200) begin
            @(negedge clk);
            took = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) check("send_timeout", 0, 1);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic expect_result(input string name, input int sum, input int cnt, input int lat);
        int w = 0;
        while (w < 20) begin
            @(negedge clk);
            w++;
            if (m_valid) break;
        end
        if (!m_valid) check({name, "_timeout"}, 0, 1);
        else begin
            check({name, "_sum"}, $signed(m_sum), sum);
            check({name, "_count"}, int'(m_count), cnt);
            if (lat > 0) check({name, "_latency"}, w, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send5(input int d, input bit l);
        int n = 0;
        bit took = 0;
        s_valid5 = 1'b1; s_data5 = 8'(d); s_last5 = l;
        while (!took && n < 200) begin
            @(negedge clk);
            took = s_ready5;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) check("send5_timeout", 0, 1);
        s_valid5 = 1'b0; s_last5 = 1'b0;
    endtask

    task automatic expect5(input string name, input int sum, input int cnt);
        int w = 0;
        while (w < 20) begin
            @(negedge clk);
            w++;
            if (m_valid5) break;
        end
        if (!m_valid5) check({name, "_timeout"}, 0, 1);
        else begin
            check({name, "_sum"}, $signed(m_sum5), sum);
            check({name, "_count"}, int'(m_count5), cnt);
            check({name, "_latency"}, w, 2);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        s_valid5 = 1'b0; s_last5 = 1'b0; s_data5 = '0; m_ready5 = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_sum", int'(m_sum), 0);
        check("rst_m_count", int'(m_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 1; i <= 4; i++) send(i, 0);
        expect_result("full", 10, 4, 2);

        for (int i = 0; i < 4; i++) send(-128, 0);
        expect_result("neg", -512, 4, 2);
        check("neg_raw", int'(m_sum), 'h200);
        for (int i = 0; i < 4; i++) send(127, 0);
        expect_result("pos", 508, 4, 2);

        send(5, 0);
        send(-7, 1);
        expect_result("short", -2, 2, 2);
        check("short_raw", int'(m_sum), 'h3FE);
        for (int i = 0; i < 4; i++) send(1, 0);
        expect_result("stale", 4, 4, 2);

        rdy_mode = 2;
        fork
            begin
                for (int i = 2; i <= 5; i++) send(i, 0);
                for (int i = 6; i <= 9; i++) send(i, 0);
            end
            begin
                int w = 0;
                while (!m_valid && w < 40) begin
                    @(negedge clk);
                    w++;
                end
                if (!m_valid) check("bp_timeout", 0, 1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_sum", $signed(m_sum), 14);
                    check("bp_count", int'(m_count), 4);
                    check("bp_s_ready", int'(s_ready), 0);
                end
                rdy_mode = 0;
            end
        join
        expect_result("bp_next", 30, 4, 2);

        send(1, 0);
        send(2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_s_ready", int'(s_ready), 1);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_sum", int'(m_sum), 0);
        check("midrst_m_count", int'(m_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 0);
        expect_result("post_rst", 4, 4, 2);

        rdy_mode = 1;
        for (int v = 0; v < 200; v++) begin
            int len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                int d;
                bit l;
                case ($urandom % 4)
                    0: d = -128;
                    1: d = 127;
                    default: d = $urandom_range(0, 255);
                endcase
                l = (j == len - 1) && ((len < 4) || ($urandom % 2 == 1));
                send(d, l);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        #1;

        for (int i = 1; i <= 5; i++) send5(i, 0);
        expect5("lanes5_full", 15, 5);
        send5(-3, 1);
        expect5("lanes5_short", -3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_lane_sum.md
# stream_lane_sum

Sequential front end for the signed adder tree. Accepts signed scalar samples over a valid/ready stream, packs them into `num_inputs` lanes with zero padding for short vectors, and drives the packed vector into the tree. Registers the tree's sum and presents it on a valid/ready output stream. It sits between a sample producer and any consumer of per-vector sums.

## Interface
- `bit_width`, 8, signed width of one input sample.
- `num_inputs`, 4, lanes per vector; any value ≥1, not required to be a power of two.
- `add_out_width`, `bit_width + $clog2(num_inputs)`, derived; not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  block can accept a sample.
- `s_data`  in  `bit_width`  signed sample.
- `s_last`  in  1  final sample of the current vector; closes a short vector.
- `m_valid`  out  1  `m_sum` / `m_count` valid.
- `m_ready`  in  1  consumer accepts the result.
- `m_sum`  out  `add_out_width`  signed sum of all lanes.
- `m_count`  out  `$clog2(num_inputs+1)`  number of lanes filled by real samples.

## Operation
- State machine with three states: FILL, SUM, OUT. Reset state is FILL.
- **FILL**
  - `s_ready=1`.
  - On each beat (`s_valid & s_ready`), `s_data` is written to lane `idx` and `idx` increments.
  - Leave for SUM when the accepted beat fills lane `num_inputs-1`, or when `s_last=1`. Both conditions on the same beat close a single vector.
- **SUM**
  - `s_ready=0`.
  - The tree output (combinational over the lane registers) is captured into `m_sum`.
  - `m_count` is set to `idx`.
  - Next state is OUT.
- **OUT**
  - `m_valid=1`, `s_ready=0`.
  - On `m_ready`: clear all lanes to zero, set `idx` to 0, return to FILL.
- Lanes not written in a short vector remain zero. The tree sign-extends every lane to `add_out_width`, and its internal padding to the next power-of-two lane count is zero. Together these make the sum exact, so overflow is impossible.
- `s_data` is treated as two's complement. Lanes hold raw bits; sign extension happens in the tree.
- Reset at any time, including mid-vector:
  - clears all lanes, `idx`, `m_sum`, `m_count`;
  - drops `m_valid` immediately;
  - returns to FILL.
  - Partially collected samples are discarded.
- Reset values: `s_ready=1` (FILL), `m_valid=0`, `m_sum=0`, `m_count=0`.

## Timing
- Closing beat accepted at edge k → SUM during cycle k..k+1 → `m_valid` high after edge k+1. Latency is 2 cycles from the last sample to the result.
- `s_ready` falls after edge k. No sample is accepted in SUM or OUT.
- `m_sum` and `m_count` are stable while `m_valid & !m_ready`. They are held for an unbounded time.
- When `m_ready` is high at edge j in OUT, `s_ready=1` after edge j. The next sample can be accepted at edge j+1.
- Full-vector throughput is one result per `num_inputs+2` cycles with `m_ready` tied high.
- `s_valid` asserted while `s_ready=0` is ignored. The producer holds the sample under normal valid/ready rules.
- `num_inputs=1`: every beat closes a vector, and `m_sum` is the sign-extended sample (`add_out_width=bit_width`).

## Structure
- Shared package `lane_sum_pkg` holds:
  - the state enum (`FILL`, `SUM`, `OUT`);
  - a width helper function returning `bit_width + $clog2(n)`.
- One sub-module: the existing signed adder tree `adder`, parameterised with `bit_width`/`num_inputs`.
  - Its `in` port is driven from the lane register array.
  - Its per-level intermediate output is left unconnected.
- Lane storage is a packed `[num_inputs-1:0][bit_width-1:0]` register.
- `idx` is `$clog2(num_inputs+1)` bits wide.

## Test plan
All scenarios use `bit_width=8`, `num_inputs=4` unless noted.

- **Full vector:** samples 1, 2, 3, 4 back-to-back with `m_ready=1` → `m_sum=10`, `m_count=4`, `m_valid` high exactly 2 cycles after the 4th beat, `s_ready` high again the cycle after.
- **Negative extreme:** four samples of -128 → `m_sum=10'h200` (-512), `m_count=4`. Then four samples of 127 → `m_sum=508`.
- **Short vector:** 5, then -7 with `s_last=1` → `m_sum=10'h3FE` (-2), `m_count=2`. Next vector 1, 1, 1, 1 → 4, proving stale lanes were cleared.
- **Backpressure:** `m_ready=0` for 5 cycles after the result → `m_sum`/`m_count` stable, `s_ready=0`, `s_valid` held by the producer with no beat lost. Release → next vector sums correctly.
- **Reset mid-fill:** reset asserted asynchronously after 2 of 4 beats → all outputs at reset values within the same cycle. After release, vector 1, 1, 1, 1 → `m_sum=4`.
- **Non-power-of-two lanes** (`num_inputs=5`): samples 1..5 → `m_sum=15` in 11 bits, `m_count=5`. Short vector -3 with `s_last` → `m_sum=-3`, `m_count=1`.
